// File: rtl/huffman_arb_pkg.sv
// Shared constants, symbol type and round-robin pick helper for the Huffman skew arbiter.
package huffman_arb_pkg;

    localparam int SYM_W_DEFAULT    = 5;
    localparam int IDLE_SYM_DEFAULT = 0;

    typedef logic [4:0] sym_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Scans up to eight request lines starting at ptr, wrapping modulo n (n <= 8, ptr < n).
    function automatic rr_pick_t rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n);
        rr_pick_t r;
        int       j;
        r.found = 1'b0;
        r.idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if ((k < n) && !r.found && valid[j[2:0]]) begin
                r.found = 1'b1;
                r.idx   = j[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/huffman_arb_rr.sv
// Combinational round-robin picker with its rotating start pointer.
module huffman_arb_rr
    import huffman_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic               i_advance,
    output logic               o_found,
    output logic [ID_W-1:0]    o_grant
);

    logic [ID_W-1:0] r_ptr;
    logic [7:0]      w_valid8;
    logic [2:0]      w_ptr3;
    rr_pick_t        w_pick;
    logic            w_unused_idx;

    always_comb begin
        w_valid8              = '0;
        w_valid8[NUM_REQ-1:0] = i_valid;
        w_ptr3                = '0;
        w_ptr3[ID_W-1:0]      = r_ptr;
        w_pick                = rr_pick(w_valid8, w_ptr3, NUM_REQ);
    end

    assign o_found      = w_pick.found;
    assign o_grant      = w_pick.idx[ID_W-1:0];
    assign w_unused_idx = ^w_pick.idx;

    // Pointer moves one past the winner so the winner goes to the back of the line.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_grant == ID_W'(NUM_REQ - 1)) ? '0 : o_grant + 1'b1;
        end
    end

endmodule

// File: rtl/huffman_skew_arbiter.sv
// Shares one serial Huffman skew encoder among NUM_REQ requesters and tags each code bit.
// Optional HUFF_ARB_STATS_EN adds saturating per-requester and idle code counters.
module huffman_skew_arbiter
    import huffman_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int SYM_W    = SYM_W_DEFAULT,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int IDLE_SYM = IDLE_SYM_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*SYM_W-1:0] req_symbol,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     enc_idle,
    input  logic                     enc_out,
    output logic [SYM_W-1:0]         enc_symbol,
    output logic                     bit_out,
    output logic                     bit_valid,
    output logic                     bit_first,
    output logic [ID_W-1:0]          bit_owner,
`ifdef HUFF_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]    stat_codes,
    output logic [15:0]              stat_idle_codes,
    input  logic                     stat_clear,
`endif
    output logic                     busy
);

    logic            w_found;
    logic [ID_W-1:0] w_grant;
    logic            w_xfer;
    logic            r_held_valid;
    logic [ID_W-1:0] r_held_owner;

    // Granted requester always has valid set, so a grant is a transfer.
    assign w_xfer = enc_idle && w_found && !reset;

    huffman_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clock     (clock),
        .reset     (reset),
        .i_valid   (req_valid),
        .i_advance (w_xfer),
        .o_found   (w_found),
        .o_grant   (w_grant)
    );

    always_comb begin
        req_ready  = '0;
        enc_symbol = SYM_W'(IDLE_SYM);
        if (w_xfer) begin
            req_ready[w_grant] = 1'b1;
            enc_symbol         = req_symbol[int'(w_grant)*SYM_W +: SYM_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_held_valid <= 1'b0;
            r_held_owner <= '0;
        end else if (enc_idle) begin
            r_held_valid <= w_xfer;
            if (w_xfer) r_held_owner <= w_grant;
        end
    end

    always_comb begin
        bit_out = enc_out;
        if (enc_idle) begin
            bit_valid = w_xfer;
            bit_first = w_xfer;
            bit_owner = w_xfer ? w_grant : '0;
        end else begin
            bit_valid = r_held_valid;
            bit_first = 1'b0;
            bit_owner = r_held_owner;
        end
    end

    assign busy = r_held_valid;

`ifdef HUFF_ARB_STATS_EN
    logic [15:0] r_stat_codes [NUM_REQ];
    logic [15:0] r_stat_idle;

    always_ff @(posedge clock) begin
        if (reset || stat_clear) begin
            for (int i = 0; i < NUM_REQ; i++) r_stat_codes[i] <= '0;
            r_stat_idle <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_xfer && (w_grant == ID_W'(i)) && (r_stat_codes[i] != 16'hFFFF))
                    r_stat_codes[i] <= r_stat_codes[i] + 16'd1;
            end
            if (enc_idle && !w_xfer && (r_stat_idle != 16'hFFFF))
                r_stat_idle <= r_stat_idle + 16'd1;
        end
    end

    always_comb begin
        stat_codes = '0;
        for (int i = 0; i < NUM_REQ; i++) stat_codes[i*16 +: 16] = r_stat_codes[i];
    end

    assign stat_idle_codes = r_stat_idle;
`endif

endmodule

// File: tb/tb_huffman_skew_arbiter.sv
// Directed self-checking bench for huffman_skew_arbiter (default 4 requesters, 5-bit symbols).
module tb_huffman_skew_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [19:0] req_symbol;
    logic [3:0]  req_ready;
    logic        enc_idle;
    logic        enc_out;
    logic [4:0]  enc_symbol;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_first;
    logic [1:0]  bit_owner;
    logic        busy;
`ifdef HUFF_ARB_STATS_EN
    logic [63:0] stat_codes;
    logic [15:0] stat_idle_codes;
    logic        stat_clear;
`endif

    int total = 0;
    int bad   = 0;
    int syms [4] = '{3, 7, 12, 30};

    huffman_skew_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_symbol (req_symbol),
        .req_ready  (req_ready),
        .enc_idle   (enc_idle),
        .enc_out    (enc_out),
        .enc_symbol (enc_symbol),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_first  (bit_first),
        .bit_owner  (bit_owner),
`ifdef HUFF_ARB_STATS_EN
        .stat_codes      (stat_codes),
        .stat_idle_codes (stat_idle_codes),
        .stat_clear      (stat_clear),
`endif
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 4'b1111;
        req_symbol = {5'd30, 5'd12, 5'd7, 5'd3};
        enc_idle   = 1'b1;
        enc_out    = 1'b0;
`ifdef HUFF_ARB_STATS_EN
        stat_clear = 1'b0;
`endif
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_sym", 32'(enc_symbol), 32'h0);
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;

        // no requests
        req_valid = 4'b0000;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h0);
        chk("t1_sym", 32'(enc_symbol), 32'h0);
        chk("t1_valid", 32'(bit_valid), 32'h0);
        tick();
        chk("t1_busy", 32'(busy), 32'h0);

        // all valid, 3-bit codes: grants rotate 0,1,2,3,0
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            enc_idle = 1'b1;
            enc_out  = n[0];
            #1;
            chk("t2_ready", 32'(req_ready), 32'(4'b0001 << (n % 4)));
            chk("t2_sym", 32'(enc_symbol), 32'(syms[n % 4]));
            chk("t2_first", 32'(bit_first), 32'h1);
            chk("t2_owner", 32'(bit_owner), 32'(n % 4));
            chk("t2_bit", 32'(bit_out), 32'(n[0]));
            tick();
            for (int b = 0; b < 2; b++) begin
                enc_idle = 1'b0;
                enc_out  = ~enc_out;
                #1;
                chk("t2_hvalid", 32'(bit_valid), 32'h1);
                chk("t2_hfirst", 32'(bit_first), 32'h0);
                chk("t2_howner", 32'(bit_owner), 32'(n % 4));
                chk("t2_busy", 32'(busy), 32'h1);
                chk("t2_hready", 32'(req_ready), 32'h0);
                chk("t2_hsym", 32'(enc_symbol), 32'h0);
                chk("t2_hbit", 32'(bit_out), 32'(enc_out));
                tick();
            end
        end

        // pointer is 1; grant 1 moves it to 2
        enc_idle  = 1'b1;
        req_valid = 4'b0010;
        #1;
        chk("t3_pre", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0011;
        #1;
        chk("t3_wrap", 32'(req_ready), 32'h1);
        chk("t3_sym0", 32'(enc_symbol), 32'd3);
        tick();
        #1;
        chk("t3_next", 32'(req_ready), 32'h2);
        chk("t3_sym1", 32'(enc_symbol), 32'd7);
        tick();

        // single-bit codes back to back from requester 2
        req_valid = 4'b0100;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("t4_ready", 32'(req_ready), 32'h4);
            chk("t4_first", 32'(bit_first), 32'h1);
            chk("t4_owner", 32'(bit_owner), 32'h2);
            chk("t4_sym", 32'(enc_symbol), 32'd12);
            tick();
            chk("t4_busy", 32'(busy), 32'h1);
        end

        // pointer 3: grant 1 moves it to 2, then reset mid-code
        req_valid = 4'b0010;
        #1;
        chk("t5_grant", 32'(req_ready), 32'h2);
        tick();
        enc_idle = 1'b0;
        #1;
        chk("t5_busy_pre", 32'(busy), 32'h1);
        chk("t5_owner_pre", 32'(bit_owner), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t5_valid_a", 32'(bit_valid), 32'h0);
        chk("t5_busy_a", 32'(busy), 32'h0);
        tick();
        chk("t5_valid_b", 32'(bit_valid), 32'h0);
        enc_idle  = 1'b1;
        req_valid = 4'b1010;
        #1;
        chk("t5_ptr0", 32'(req_ready), 32'h2);
        chk("t5_owner", 32'(bit_owner), 32'h1);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("t5_idle_owner", 32'(bit_owner), 32'h0);
        chk("t5_idle_valid", 32'(bit_valid), 32'h0);
        tick();
        chk("t5_idle_busy", 32'(busy), 32'h0);

`ifdef HUFF_ARB_STATS_EN
        req_valid = 4'b0010;
        enc_idle  = 1'b1;
        for (int n = 0; n < 70000; n++) tick();
        chk("t6_sat", 32'(stat_codes[31:16]), 32'hFFFF);
        req_valid  = 4'b0000;
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        chk("t6_clear", 32'(stat_codes[31:16]), 32'h0);
        chk("t6_clear_idle", 32'(stat_idle_codes), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
